// File: rtl/furv_lsu_if.sv
// Core request/response and word-wide bus signals of the load/store unit.
// The LSU takes the slave modport; the core and memory side takes the master modport.
interface furv_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [1:0]                 req_width;
  logic                       req_unsigned;
  logic [ADDR_W-1:0]          req_addr;
  logic [31:0]                req_wdata;
  logic                       resp_valid;
  logic [31:0]                resp_rdata;
  logic                       resp_err;
  logic                       mem;
  logic                       mem_write;
  logic [ADDR_W-OFF_W-1:0]    addr;
  logic [DATA_W/8-1:0]        sel;
  logic [DATA_W-1:0]          data_out;
  logic [DATA_W-1:0]          data_in;
  logic                       ack;

  modport master (
    output req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem, mem_write, addr, sel, data_out,
    output data_in, ack
  );

  modport slave (
    input  req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem, mem_write, addr, sel, data_out,
    input  data_in, ack
  );
endinterface

// File: rtl/furv_lsu.sv
// furv_lsu: turns byte/half/word core accesses into one or two word-wide bus beats.
// Optional macro FURV_LSU_MISALIGNED_EN: execute misaligned accesses instead of rejecting them.
module furv_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  furv_lsu_if.slave lsu
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int WA_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state, state_nxt;

  logic                write_q;
  logic                unsigned_q;
  logic                err_q;
  logic [1:0]          width_q;
  logic [OFF_W-1:0]    off_q;
  logic [WA_W-1:0]     wa_q;
  logic [31:0]         wdata_q;
  logic [DATA_W-1:0]   rd0_q;
  logic [DATA_W-1:0]   rd1_q;

  logic                accept;
  logic                req_err;
  logic [OFF_W+2:0]    bit_off;
  logic [2*BYTES-1:0]  sel_wide;
  logic [2*DATA_W-1:0] wd_wide;
  logic [31:0]         ld_raw;

  function automatic logic [BYTES-1:0] lane_mask(input logic [1:0] w);
    logic [BYTES-1:0] m;
    m    = '0;
    m[0] = 1'b1;
    if (w != 2'd0) m[1] = 1'b1;
    if (w == 2'd2) m[3:2] = 2'b11;
    return m;
  endfunction

  function automatic int size_bytes(input logic [1:0] w);
    case (w)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] size_data(input logic [31:0] d, input logic [1:0] w);
    case (w)
      2'd0:    return {24'h0, d[7:0]};
      2'd1:    return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] w,
                                              input logic uns);
    case (w)
      2'd0:    return {{24{~uns & raw[7]}}, raw[7:0]};
      2'd1:    return {{16{~uns & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign accept = (state == IDLE) && lsu.req_valid;

`ifdef FURV_LSU_MISALIGNED_EN
  logic cross_q;

  assign req_err = (lsu.req_width == 2'd3);

  // An access crosses into the next bus word when its last byte lies past the last lane.
  always_ff @(posedge clk) begin
    if (accept)
      cross_q <= (int'(lsu.req_addr[OFF_W-1:0]) + size_bytes(lsu.req_width)) > BYTES;
  end
`else
  logic req_misal;

  assign req_misal = ((lsu.req_width == 2'd1) && lsu.req_addr[0]) ||
                     ((lsu.req_width == 2'd2) && (lsu.req_addr[1:0] != 2'b00));
  assign req_err   = (lsu.req_width == 2'd3) || req_misal;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lsu.req_valid) state_nxt = req_err ? RESP : BEAT0;
      BEAT0: begin
        if (lsu.ack) begin
`ifdef FURV_LSU_MISALIGNED_EN
          state_nxt = cross_q ? BEAT1 : RESP;
`else
          state_nxt = RESP;
`endif
        end
      end
      BEAT1:   if (lsu.ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once on acceptance; bus beats capture their read data on ack.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q    <= lsu.req_write;
      unsigned_q <= lsu.req_unsigned;
      err_q      <= req_err;
      width_q    <= lsu.req_width;
      off_q      <= lsu.req_addr[OFF_W-1:0];
      wa_q       <= lsu.req_addr[ADDR_W-1:OFF_W];
      wdata_q    <= lsu.req_wdata;
      rd1_q      <= '0;
    end
    if ((state == BEAT0) && lsu.ack) rd0_q <= lsu.data_in;
    if ((state == BEAT1) && lsu.ack) rd1_q <= lsu.data_in;
  end

  // Shifting across two bus words yields beat0 lanes in the low half and beat1 lanes in the high half.
  assign bit_off  = {off_q, 3'b000};
  assign sel_wide = {{BYTES{1'b0}}, lane_mask(width_q)} << off_q;
  assign wd_wide  = {{(2*DATA_W-32){1'b0}}, size_data(wdata_q, width_q)} << bit_off;
  assign ld_raw   = 32'({rd1_q, rd0_q} >> bit_off);

  always_comb begin
    lsu.mem       = 1'b0;
    lsu.mem_write = 1'b0;
    lsu.addr      = '0;
    lsu.sel       = '0;
    lsu.data_out  = '0;
    if (state == BEAT0) begin
      lsu.mem       = 1'b1;
      lsu.mem_write = write_q;
      lsu.addr      = wa_q;
      lsu.sel       = sel_wide[BYTES-1:0];
      lsu.data_out  = write_q ? wd_wide[DATA_W-1:0] : '0;
    end else if (state == BEAT1) begin
      lsu.mem       = 1'b1;
      lsu.mem_write = write_q;
      lsu.addr      = wa_q + WA_W'(1);
      lsu.sel       = sel_wide[2*BYTES-1:BYTES];
      lsu.data_out  = write_q ? wd_wide[2*DATA_W-1:DATA_W] : '0;
    end
  end

  assign lsu.req_ready  = (state == IDLE);
  assign lsu.resp_valid = (state == RESP);
  assign lsu.resp_err   = (state == RESP) && err_q;
  assign lsu.resp_rdata = ((state == RESP) && !write_q && !err_q) ?
                          extend_load(ld_raw, width_q, unsigned_q) : 32'h0;
endmodule

// File: doc/furv_lsu.md
FURV_LSU -- requirements
Module: furv_lsu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning bus data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; it is synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit, core access request.
REQ-006 SHALL have port req_ready, output, 1 bit, request accepted when it and req_valid are high at posedge.
REQ-007 SHALL have port req_write, input, 1 bit, 1 = store, 0 = load.
REQ-008 SHALL have port req_width, input, 2 bits, 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 SHALL have port req_unsigned, input, 1 bit, zero-extend loads (LBU/LHU).
REQ-010 SHALL have port req_addr, input, ADDR_W bits, byte address.
REQ-011 SHALL have port req_wdata, input, 32 bits, store data, LSB-aligned.
REQ-012 SHALL have port resp_valid, output, 1 bit, one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata, output, 32 bits, extended load data; 0 for stores.
REQ-014 SHALL have port resp_err, output, 1 bit, access rejected; valid with resp_valid.
REQ-015 SHALL have port mem, output, 1 bit, bus cycle active.
REQ-016 SHALL have port mem_write, output, 1 bit, bus write strobe.
REQ-017 SHALL have port addr, output, ADDR_W-log2(DATA_W/8) bits, bus word address.
REQ-018 SHALL have port sel, output, DATA_W/8 bits, byte lane enables.
REQ-019 SHALL have port data_out, output, DATA_W bits, store data on byte lanes.
REQ-020 SHALL have port data_in, input, DATA_W bits, load data from bus.
REQ-021 SHALL have port ack, input, 1 bit, bus beat complete; sampled at posedge while mem=1.

Function
REQ-022 SHALL implement FSM IDLE -> BEAT0 -> [BEAT1] -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-023 SHALL latch all req_* fields on acceptance; later req_* changes have no effect until next IDLE.
REQ-024 SHALL hold mem=1 and addr/sel/data_out/mem_write stable in BEAT0/BEAT1 until the cycle after ack; mem=0 in IDLE and RESP.
REQ-025 SHALL leave BEAT0 on ack: to BEAT1 if access crosses a bus-word boundary, else RESP; BEAT1 exits to RESP on ack.
REQ-026 SHALL set sel to the bytes [offset, offset+size) within each beat's bus word; data_out places req_wdata bytes on those lanes, other lanes 0.
REQ-027 SHALL assemble load bytes from the selected lanes (beat0 low bytes, beat1 high bytes), sign-extend unless req_unsigned, zero-extend if set; words ignore req_unsigned.
REQ-028 SHALL pulse resp_valid for exactly one cycle in RESP; minimum latency is accept edge t, mem=1 in cycle t+1, resp_valid in cycle t+2 with ack at t+1.
REQ-029 SHALL treat req_width=3 as error: straight to RESP with resp_err=1, no bus cycle.
REQ-030 SHALL wait indefinitely for ack (no timeout); ack while mem=0 is ignored.
REQ-031 SHALL compute bus word address wrap modulo 2^ADDR_W for the second beat at the top address.

Reset
REQ-032 SHALL, while rst_n=0 at posedge, force IDLE, req_ready=1 after release, mem=0, mem_write=0, addr=0, sel=0, data_out=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-033 SHALL abandon an in-flight access on reset; mem=0 from the next edge, no resp_valid issued.

Configuration
REQ-034 SHALL, with FURV_LSU_MISALIGNED_EN defined, execute misaligned accesses (one beat if within a bus word, two beats if crossing) with resp_err=0.
REQ-035 SHALL, without FURV_LSU_MISALIGNED_EN, reject any access whose address is not a multiple of its size: no bus cycle, RESP with resp_err=1; BEAT1 does not exist.

Verification
REQ-036 SHALL cover LW 0x100, data_in=0xDEADBEEF, ack at t+1 -> addr=0x40, sel=1111, resp_rdata=0xDEADBEEF, resp_valid at t+2.
REQ-037 SHALL cover LB 0x103, data_in=0x80000000 -> sel=1000, resp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SHALL cover SH 0x202, wdata=0x1234ABCD, ack delayed 3 cycles -> mem_write=1, sel=1100, data_out=0xABCD0000 held stable 3 cycles.
REQ-039 SHALL cover LW 0x102, beats return 0x56780000 and 0x00001234 -> with macro: addr 0x40 sel 1100 then 0x41 sel 0011, rdata=0x12345678; without: resp_err=1, mem never high.
REQ-040 SHALL cover rst_n=0 during BEAT0 with ack low -> mem=0 next edge, no resp_valid, req_ready=1 after release.
REQ-041 SHALL cover DATA_W=64 LW 0x104 -> single beat, addr=0x20, sel=0xF0, data from data_in[63:32].
